small_poly_encoder: RTL and testbench

//  Reader side of the short-polynomial memory that the ternary short-poly generator fills.
//  On start, reads P coefficients from addresses 0..P-1 in order.

---
 rtl/small_poly_encoder.sv | 194 +++++++++++++++++++
 tb/tb_small_poly_encoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/small_poly_encoder.sv
// Reads P ternary coefficients from the short-poly RAM, packs 4 per byte (2 bits each)
// and streams the bytes over valid/ready while tracking Hamming weight and bad words.
module small_poly_encoder #(
    parameter int unsigned P      = 757,
    parameter int unsigned W      = 286,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] weight,
    output logic              weight_ok
);

    localparam int unsigned NB      = (P + 3) / 4;
    localparam int unsigned LAST_B4 = 4 * (NB - 1);
    localparam int unsigned AW1     = ADDR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        cyc_q, cyc_d;
    logic [ADDR_W-1:0] b4_q, b4_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic [7:0]        byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] weight_q, weight_d;
    logic              wok_q, wok_d;

    logic [AW1-1:0]    k_iss, k_cap;
    logic [1:0]        field;
    logic              field_nz, field_bad;

    // Slot being addressed next cycle, and slot whose RAM data is on mem_rd_data now.
    assign k_iss = AW1'(b4_q) + AW1'(cyc_q) + AW1'(1);
    assign k_cap = AW1'(b4_q) + AW1'(cyc_q) - AW1'(1);

    always_comb begin
        field     = 2'b01;
        field_nz  = 1'b0;
        field_bad = 1'b0;
        if (k_cap >= AW1'(P)) begin
            field = 2'b00;
        end else if (mem_rd_data == DATA_W'(0)) begin
            field = 2'b01;
        end else if (mem_rd_data == DATA_W'(1)) begin
            field    = 2'b10;
            field_nz = 1'b1;
        end else if (mem_rd_data == {DATA_W{1'b1}}) begin
            field    = 2'b00;
            field_nz = 1'b1;
        end else begin
            field_bad = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        b4_d     = b4_q;
        addr_d   = addr_q;
        rd_en_d  = 1'b0;
        byte_d   = byte_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        weight_d = weight_q;
        wok_d    = wok_q;
        case (state_q)
            S_IDLE: begin
                // A start landing on the done cycle is dropped.
                if (start && !done_q) begin
                    state_d  = S_READ;
                    cyc_d    = 3'd0;
                    b4_d     = '0;
                    addr_d   = '0;
                    rd_en_d  = 1'b1;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    weight_d = '0;
                    wok_d    = 1'b0;
                    last_d   = 1'b0;
                end
            end
            S_READ: begin
                cyc_d = cyc_q + 3'd1;
                if (cyc_q < 3'd3 && k_iss < AW1'(P)) begin
                    addr_d  = k_iss[ADDR_W-1:0];
                    rd_en_d = 1'b1;
                end
                if (cyc_q >= 3'd1) begin
                    byte_d = {field, byte_q[7:2]};
                    if (field_nz) begin
                        weight_d = weight_q + ADDR_W'(1);
                    end
                    if (field_bad) begin
                        err_d = 1'b1;
                    end
                end
                if (cyc_q == 3'd4) begin
                    state_d = S_EMIT;
                    valid_d = 1'b1;
                    last_d  = (b4_q == ADDR_W'(LAST_B4));
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_READ;
                        cyc_d   = 3'd0;
                        b4_d    = b4_q + ADDR_W'(4);
                        addr_d  = b4_q + ADDR_W'(4);
                        rd_en_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                wok_d   = (weight_q == ADDR_W'(W)) && !err_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            b4_q     <= '0;
            addr_q   <= '0;
            rd_en_q  <= 1'b0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            weight_q <= '0;
            wok_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            b4_q     <= b4_d;
            addr_q   <= addr_d;
            rd_en_q  <= rd_en_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            weight_q <= weight_d;
            wok_q    <= wok_d;
        end
    end

    assign mem_address_o = addr_q;
    assign mem_rd_en     = rd_en_q;
    assign out_byte      = byte_q;
    assign out_valid     = valid_q;
    assign out_last      = last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign weight        = weight_q;
    assign weight_ok     = wok_q;

endmodule

// File: tb/tb_small_poly_encoder.sv
// Directed/randomized bench for small_poly_encoder against a coefficient-level packing model.
module tb_small_poly_encoder;

    localparam int P      = 757;
    localparam int W      = 286;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 13;
    localparam int NB     = (P + 3) / 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] mem_address_o;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] weight;
    logic              weight_ok;

    logic [DATA_W-1:0] mem [P];
    int nvec = 0;
    int nerr = 0;

    small_poly_encoder #(.P(P), .W(W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_address_o(mem_address_o), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done), .err(err), .weight(weight), .weight_ok(weight_ok)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM holding the polynomial.
    always @(posedge clk) begin
        if (mem_rd_en && int'(mem_address_o) < P) mem_rd_data <= mem[mem_address_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int k);
        if (k >= P) return 2'b00;
        case (mem[k])
            13'h0000: return 2'b01;
            13'h0001: return 2'b10;
            13'h1FFF: return 2'b00;
            default:  return 2'b01;
        endcase
    endfunction

    task automatic fill_zero();
        for (int i = 0; i < P; i++) mem[i] = '0;
    endtask

    task automatic fill_ternary();
        for (int i = 0; i < P; i++) begin
            case ($urandom_range(0, 2))
                0: mem[i] = 13'h0000;
                1: mem[i] = 13'h0001;
                default: mem[i] = 13'h1FFF;
            endcase
        end
    endtask

    task automatic run_stream(input int stall_b, input int stall_n, input bit rand_rdy, input bit inject);
        logic [7:0] exp_b [NB];
        int exp_w = 0;
        bit exp_e = 0;
        int idx = 0;
        int cyc = 0;
        int stall_cnt = 0;
        bit seen = 0;
        logic [7:0] held = '0;
        logic held_last = 1'b0;
        for (int b = 0; b < NB; b++) begin
            exp_b[b] = 8'(enc(4*b)) | (8'(enc(4*b+1)) << 2) | (8'(enc(4*b+2)) << 4) | (8'(enc(4*b+3)) << 6);
        end
        for (int i = 0; i < P; i++) begin
            if (mem[i] == 13'h0001 || mem[i] == 13'h1FFF) exp_w++;
            else if (mem[i] != 13'h0000) exp_e = 1;
        end
        @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_addr", 32'(mem_address_o), 0);
        chk("start_rden", 32'(mem_rd_en), 1);
        chk("start_busy", 32'(busy), 1);
        while (idx < NB && cyc < 20000) begin
            if (inject) start = (cyc == 40);
            chk("rd_range", 32'(mem_rd_en && int'(mem_address_o) >= P), 0);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    held = out_byte;
                    held_last = out_last;
                    chk($sformatf("byte%0d", idx), 32'(out_byte), 32'(exp_b[idx]));
                    chk($sformatf("last%0d", idx), 32'(out_last), 32'(idx == NB - 1));
                    if (idx == 0) chk("first_valid_lat", cyc, 5);
                end else begin
                    chk("hold_byte", 32'(out_byte), 32'(held));
                    chk("hold_last", 32'(out_last), 32'(held_last));
                    chk("stall_rden", 32'(mem_rd_en), 0);
                end
                if (idx == stall_b && stall_cnt < stall_n) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end else if (rand_rdy && $urandom_range(0, 2) == 0) begin
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    idx++;
                    seen = 0;
                end
            end else begin
                out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("byte_count", idx, NB);
        chk("fin_done", 32'(done), 0);
        chk("fin_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("done", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_valid", 32'(out_valid), 0);
        chk("weight", 32'(weight), 32'(exp_w));
        chk("err", 32'(err), 32'(exp_e));
        chk("weight_ok", 32'(weight_ok), 32'(exp_w == W && !exp_e));
        if (inject) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("hold_weight", 32'(weight), 32'(exp_w));
        chk("hold_wok", 32'(weight_ok), 32'(exp_w == W && !exp_e));
    endtask

    initial begin
        int cnt;
        int pos;
        fill_zero();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", {mem_address_o, mem_rd_en, out_byte, out_valid, out_last}, 0);
        chk("rst_b", {busy, done, err, weight, weight_ok}, 0);
        #1 rst = 1'b0;

        // Abort after three addresses issued, then restart cleanly.
        mem[0] = 13'h0001;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("mid_addr", 32'(mem_address_o), 2);
        rst = 1'b1; #1;
        chk("mid_rst_a", {mem_address_o, mem_rd_en, out_byte, out_valid, out_last}, 0);
        chk("mid_rst_b", {busy, done, err, weight, weight_ok}, 0);
        @(posedge clk); #1 rst = 1'b0;
        mem[0] = 13'h0000;

        run_stream(-1, 0, 0, 0);

        mem[0] = 13'h0001; mem[1] = 13'h1FFF; mem[2] = 13'h0000; mem[3] = 13'h0001;
        run_stream(-1, 0, 0, 0);

        fill_zero();
        cnt = 0;
        while (cnt < W) begin
            pos = $urandom_range(0, P - 1);
            if (mem[pos] == 13'h0000) begin
                mem[pos] = (cnt % 2 == 0) ? 13'h0001 : 13'h1FFF;
                cnt++;
            end
        end
        run_stream(-1, 0, 0, 0);

        fill_ternary();
        run_stream(5, 10, 0, 0);

        fill_ternary();
        mem[400] = 13'h0002;
        run_stream(-1, 0, 0, 0);

        fill_ternary();
        run_stream(-1, 0, 0, 1);

        fill_ternary();
        mem[$urandom_range(0, P - 1)] = 13'(13'h0003 + $urandom_range(0, 100));
        run_stream(-1, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
